// File: rtl/spike_pkg.sv
// Shared types and constants for the spike-train decoder: FSM states,
// event-word layout helpers and the event FIFO depth.
package spike_pkg;

  typedef enum logic {
    ARMED  = 1'b0,
    FIRING = 1'b1
  } state_t;

  localparam int FIFO_DEPTH  = 2;
  localparam int EVT_ISI_LSB = 0;

  // Event word is {first, burst, isi}; positions depend on the ISI width.
  function automatic int evtBurstPos(input int isiW);
    return isiW;
  endfunction

  function automatic int evtFirstPos(input int isiW);
    return isiW + 1;
  endfunction

  function automatic int evtWidth(input int isiW);
    return isiW + 2;
  endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Small event FIFO; a push on a full FIFO is accepted only when a pop
// happens on the same edge.
module spike_evt_fifo
  import spike_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [W-1:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [PW:0]   r_count;
  logic          w_pop;
  logic          w_push;
  logic          w_full;

  assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_data  = r_mem[r_rdPtr];
  assign o_valid = (r_count != '0);
  assign o_full  = w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spike_train_decoder.sv
// Hysteresis spike detector emitting {first, burst, isi} events through a
// 2-entry FIFO. Define SPIKE_DEC_RATE_EN to build the per-window rate counter.
module spike_train_decoder
  import spike_pkg::*;
#(
  parameter int ISI_W     = 16,
  parameter int BURST_ISI = 8,
  parameter int WIN       = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       v_in,
  input  logic             v_valid,
  input  logic [7:0]       thr_hi,
  input  logic [7:0]       thr_lo,
  output logic             spike,
  output logic [ISI_W+1:0] evt_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             ovf,
  output logic [7:0]       rate,
  output logic             rate_valid
);

  localparam logic [ISI_W-1:0] ISI_MAX   = '1;
  localparam int               BURST_POS = evtBurstPos(ISI_W);
  localparam int               FIRST_POS = evtFirstPos(ISI_W);
  localparam int               EVT_W     = evtWidth(ISI_W);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_detect;
  logic [ISI_W-1:0] r_isiCnt;
  logic             r_first;
  logic             r_spike;
  logic             r_ovf;
  logic [ISI_W-1:0] w_isi;
  logic             w_burst;
  logic [EVT_W-1:0] w_evtWord;
  logic             w_full;
  logic             w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARMED;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (v_valid) begin
      case (r_state)
        ARMED:   if ($signed(v_in) > $signed(thr_hi)) w_nextState = FIRING;
        FIRING:  if ($signed(v_in) < $signed(thr_lo)) w_nextState = ARMED;
        default: w_nextState = ARMED;
      endcase
    end
  end

  always_comb begin
    w_detect = (r_state == ARMED) && v_valid && ($signed(v_in) > $signed(thr_hi));
  end

  // The interval includes the spike sample itself, hence counter+1.
  assign w_isi   = (r_isiCnt == ISI_MAX) ? ISI_MAX : r_isiCnt + 1'b1;
  assign w_burst = !r_first && (32'(w_isi) <= 32'(BURST_ISI));

  always_comb begin
    w_evtWord                          = '0;
    w_evtWord[EVT_ISI_LSB +: ISI_W]    = r_first ? ISI_MAX : w_isi;
    w_evtWord[BURST_POS]               = w_burst;
    w_evtWord[FIRST_POS]               = r_first;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_isiCnt <= '0;
      r_first  <= 1'b1;
      r_spike  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_spike <= w_detect;
      if (v_valid) begin
        if (w_detect)                r_isiCnt <= '0;
        else if (r_isiCnt != ISI_MAX) r_isiCnt <= r_isiCnt + 1'b1;
      end
      if (w_detect) r_first <= 1'b0;
      if (w_detect && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign w_pop = evt_valid && evt_ready;
  assign spike = r_spike;
  assign ovf   = r_ovf;

  spike_evt_fifo #(
    .W(EVT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_detect),
    .i_data (w_evtWord),
    .i_pop  (w_pop),
    .o_data (evt_data),
    .o_valid(evt_valid),
    .o_full (w_full)
  );

`ifdef SPIKE_DEC_RATE_EN
  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;

  logic [WCW-1:0] r_winCnt;
  logic [7:0]     r_spkCnt;
  logic [7:0]     r_rate;
  logic           r_rateValid;
  logic [7:0]     w_spkNext;

  assign w_spkNext = (!w_detect || r_spkCnt == 8'hFF) ? r_spkCnt : r_spkCnt + 8'd1;

  // A spike on the last sample of a window is counted into that window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_winCnt    <= '0;
      r_spkCnt    <= '0;
      r_rate      <= '0;
      r_rateValid <= 1'b0;
    end else begin
      r_rateValid <= 1'b0;
      if (v_valid) begin
        if (r_winCnt == WCW'(WIN - 1)) begin
          r_rate      <= w_spkNext;
          r_rateValid <= 1'b1;
          r_winCnt    <= '0;
          r_spkCnt    <= '0;
        end else begin
          r_winCnt <= r_winCnt + 1'b1;
          r_spkCnt <= w_spkNext;
        end
      end
    end
  end

  assign rate       = r_rate;
  assign rate_valid = r_rateValid;
`else
  assign rate       = 8'd0;
  assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_train_decoder.sv
// Directed self-checking bench for spike_train_decoder (rate checks follow
// SPIKE_DEC_RATE_EN).
module tb_spike_train_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  v_in = 8'd0;
  logic        v_valid = 1'b0;
  logic [7:0]  thr_hi = 8'd20;
  logic [7:0]  thr_lo = 8'hD8;
  logic        spike;
  logic [17:0] evt_data;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic        ovf;
  logic [7:0]  rate;
  logic        rate_valid;

  int checks   = 0;
  int failures = 0;

`ifdef SPIKE_DEC_RATE_EN
  localparam logic [7:0] EXP_RATE = 8'd3;
  localparam logic       EXP_RV   = 1'b1;
`else
  localparam logic [7:0] EXP_RATE = 8'd0;
  localparam logic       EXP_RV   = 1'b0;
`endif

  always #5 clk = ~clk;

  spike_train_decoder #(
    .ISI_W(16),
    .BURST_ISI(8),
    .WIN(16)
  ) dut (
    .clk(clk), .rst(rst), .v_in(v_in), .v_valid(v_valid),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .spike(spike),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .ovf(ovf), .rate(rate), .rate_valid(rate_valid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    @(negedge clk);
    v_in    = v;
    v_valid = 1'b1;
    @(posedge clk);
    #1;
    v_valid = 1'b0;
  endtask

  task automatic idleCycle;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic popEvent(input string tag, input logic [17:0] exp);
    checkOutput({tag, "_valid"}, 32'(evt_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(evt_data), 32'(exp));
    @(negedge clk);
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    evt_ready = 1'b0;
  endtask

  task automatic doReset;
    @(negedge clk);
    rst       = 1'b1;
    v_valid   = 1'b0;
    evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] hystV [6];
  logic       hystS [6];
  logic [7:0] rateV [16];

  initial begin
    hystV = '{8'hC4, 8'd25, 8'd30, 8'hE2, 8'hCE, 8'd25};
    hystS = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state observed while rst is held high
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_spike", 32'(spike), 32'd0);
    checkOutput("rst_evt_valid", 32'(evt_valid), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_rate", 32'(rate), 32'd0);
    checkOutput("rst_rate_valid", 32'(rate_valid), 32'd0);
    rst = 1'b0;

    // Threshold hysteresis
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(hystV[i]);
      checkOutput($sformatf("hyst_spike%0d", i), 32'(spike), 32'(hystS[i]));
    end
    evt_ready = 1'b0;

    // ISI and first flag: spikes on valid samples 3, 7, 17
    doReset;
    applyStimulus(8'd0);
    applyStimulus(8'd0);
    applyStimulus(8'd25);
    checkOutput("isi_spike3", 32'(spike), 32'd1);
    popEvent("isi_ev1", 18'h2FFFF);
    applyStimulus(8'hCE);
    applyStimulus(8'd0);
    applyStimulus(8'd0);
    applyStimulus(8'd25);
    popEvent("isi_ev2", 18'h10004);
    applyStimulus(8'hCE);
    for (int i = 0; i < 8; i++) applyStimulus(8'd0);
    applyStimulus(8'd25);
    popEvent("isi_ev3", 18'h0000A);
    checkOutput("isi_ovf", 32'(ovf), 32'd0);

    // ISI saturation after a long quiet stretch
    applyStimulus(8'hCE);
    @(negedge clk);
    v_in    = 8'd0;
    v_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    v_valid = 1'b0;
    applyStimulus(8'd25);
    popEvent("sat_ev", 18'h0FFFF);

    // Backpressure: three spikes with evt_ready low
    doReset;
    applyStimulus(8'd25);
    applyStimulus(8'hCE);
    applyStimulus(8'd25);
    checkOutput("bp_ovf_before", 32'(ovf), 32'd0);
    applyStimulus(8'hCE);
    applyStimulus(8'd25);
    checkOutput("bp_ovf_after", 32'(ovf), 32'd1);
    popEvent("bp_ev1", 18'h2FFFF);
    popEvent("bp_ev2", 18'h10002);
    checkOutput("bp_empty", 32'(evt_valid), 32'd0);
    checkOutput("bp_ovf_sticky", 32'(ovf), 32'd1);

    // Full FIFO with pop and push on the same edge
    doReset;
    applyStimulus(8'd25);
    applyStimulus(8'hCE);
    applyStimulus(8'd25);
    applyStimulus(8'hCE);
    applyStimulus(8'd0);
    applyStimulus(8'd0);
    evt_ready = 1'b1;
    applyStimulus(8'd25);
    evt_ready = 1'b0;
    checkOutput("pp_ovf", 32'(ovf), 32'd0);
    popEvent("pp_ev2", 18'h10002);
    popEvent("pp_ev3", 18'h10004);
    checkOutput("pp_empty", 32'(evt_valid), 32'd0);

    // Asynchronous reset mid-FIRING with one queued event
    doReset;
    applyStimulus(8'd25);
    checkOutput("ar_spike_pre", 32'(spike), 32'd1);
    checkOutput("ar_valid_pre", 32'(evt_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid_async", 32'(evt_valid), 32'd0);
    checkOutput("ar_spike_async", 32'(spike), 32'd0);
    rst = 1'b0;
    applyStimulus(8'd25);
    checkOutput("ar_spike_post", 32'(spike), 32'd1);
    popEvent("ar_ev", 18'h2FFFF);

    // Rate window of 16 samples with 3 spikes
    doReset;
    evt_ready = 1'b1;
    rateV = '{8'd25, 8'hCE, 8'd25, 8'hCE, 8'd25, 8'd0, 8'd0, 8'd0,
              8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 15; i++) applyStimulus(rateV[i]);
    checkOutput("rate_valid_early", 32'(rate_valid), 32'd0);
    applyStimulus(rateV[15]);
    checkOutput("rate_value", 32'(rate), 32'(EXP_RATE));
    checkOutput("rate_valid_pulse", 32'(rate_valid), 32'(EXP_RV));
    idleCycle;
    checkOutput("rate_valid_drop", 32'(rate_valid), 32'd0);
    checkOutput("rate_hold", 32'(rate), 32'(EXP_RATE));
    evt_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_train_decoder.md
SPIKE_TRAIN_DECODER -- requirements
Module: spike_train_decoder

Interface
REQ-001 Parameter ISI_W, default 16: width of the inter-spike-interval (ISI) field, in samples.
REQ-002 Parameter BURST_ISI, default 8: an ISI at or below this value marks a spike as a burst spike.
REQ-003 Parameter WIN, default 256: rate window length, in valid samples; used only when SPIKE_DEC_RATE_EN is defined.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port v_in, input, 8: signed membrane-voltage sample, top 8 bits of the neuron's 2.16 state.
REQ-007 Port v_valid, input, 1: v_in holds a new sample this cycle.
REQ-008 Port thr_hi, input, 8: signed spike-detect threshold.
REQ-009 Port thr_lo, input, 8: signed re-arm threshold.
REQ-010 Port spike, output, 1: one-cycle pulse per detected spike.
REQ-011 Port evt_data, output, ISI_W+2: event word {first, burst, isi}.
REQ-012 Port evt_valid/evt_ready, output/input, 1 each: valid/ready handshake for event words.
REQ-013 Port ovf, output, 1: sticky flag, set when an event was dropped.
REQ-014 Port rate/rate_valid, output, 8/1: spike count per window, and a pulse when that count updates.

Function
REQ-015 FSM states:
- ARMED: on a v_valid sample with v_in > thr_hi (signed, strict), detect a spike and go to FIRING.
- FIRING: on a v_valid sample with v_in < thr_lo (signed, strict), go to ARMED.
- Cycles without v_valid change no state.
REQ-016 spike is registered: it is high in the cycle after the clock edge that sampled the detecting v_in.
REQ-017 ISI counter:
- Increments on every v_valid sample and saturates at 2^ISI_W-1.
- On a spike sample, isi = min(counter+1, 2^ISI_W-1), then the counter clears to 0.
REQ-018 Event fields:
- first = 1 for the first spike after reset; its isi field is all-ones.
- burst = 1 when first = 0 and isi <= BURST_ISI.
REQ-019 Each spike pushes one event into a 2-entry FIFO in the same edge that raises spike, so evt_valid rises together with spike when the FIFO was empty.
REQ-020 A pop occurs when evt_valid and evt_ready are both high; evt_data holds stable while evt_valid is high and evt_ready is low.
REQ-021 Overflow handling:
- FIFO full with no pop in the same cycle: the new event is dropped and ovf sets; ovf clears only on reset.
- FIFO full with a pop in the same cycle: pop then push, no drop.
REQ-022 The 8-bit rate counter saturates at 255.

Reset
REQ-023 While rst is high: FSM is ARMED, ISI counter is 0, the first-spike flag is set, the FIFO is empty, and spike, evt_valid, ovf, rate and rate_valid are all 0.
REQ-024 Reset asserted mid-operation discards all queued events and any partial window immediately, without waiting for a clock edge.

Configuration
REQ-025 Macro SPIKE_DEC_RATE_EN defined: a window counter counts WIN valid samples. At the last sample of each window, rate is loaded with the spikes counted in that window (including a spike on that sample), rate_valid pulses for 1 cycle, and counting restarts.
REQ-026 Macro SPIKE_DEC_RATE_EN undefined: the rate logic is absent and rate and rate_valid are tied to 0.

Structure
REQ-027 Shared package spike_pkg holds:
- the FSM state enum (ARMED, FIRING);
- the event-word field widths and bit positions;
- the FIFO depth constant (2).
REQ-028 The event FIFO is a separate sub-module, spike_evt_fifo; the decoder instantiates exactly one.

Verification
REQ-029 The bench shall cover these directed scenarios:
- Threshold hysteresis: thr_hi=20, thr_lo=-40; v_in sequence -60,25,30,-30,-50,25 -> exactly 2 spike pulses, on the samples 25 (2nd) and 25 (6th).
- ISI and first flag: spikes on valid samples 3, 7 and 17 after reset, BURST_ISI=8 -> events {1,0,FFFF}, {0,1,4}, {0,0,10}.
- Saturation: 70000 valid samples with no spike, then one spike -> isi field = 0xFFFF.
- Backpressure: evt_ready held low over 3 spikes -> first two events retained in order, third dropped, ovf=1; evt_ready then high -> 2 pops, then evt_valid=0.
- Full FIFO with simultaneous pop and push -> no drop, ovf stays 0.
- Async reset asserted mid-FIRING with 1 event queued -> evt_valid and spike go 0 without a clock edge; the next spike reports first=1. With SPIKE_DEC_RATE_EN defined and WIN=16, 3 spikes in a window -> rate=3 with a 1-cycle rate_valid.
